// File: rtl/mac_seq_ctrl_if.sv
// Bundle of the command, operand, MAC-datapath and result signals of mac_seq_ctrl.
// The master side drives jobs and hosts the MAC datapath; the slave side is the sequencer.
interface mac_seq_ctrl_if #(
    parameter int LEN_W = 6
);
    logic             start;
    logic [3:0]       mode_cfg;
    logic [LEN_W-1:0] len_cfg;
    logic [23:0]      bias_int;
    logic [17:0]      bias_fp;
    logic             abort;
    logic             in_valid;
    logic [15:0]      in_value;
    logic [15:0]      in_weight;
    logic             in_ready;
    logic [3:0]       mac_mode;
    logic [15:0]      mac_value;
    logic [15:0]      mac_weight;
    logic [23:0]      mac_ints;
    logic [17:0]      mac_fps;
    logic [23:0]      mac_intr;
    logic [17:0]      mac_fpr;
    logic             res_valid;
    logic             res_ready;
    logic [23:0]      res_int;
    logic [17:0]      res_fp;
    logic             busy;

    modport master (
        output start, mode_cfg, len_cfg, bias_int, bias_fp, abort,
        output in_valid, in_value, in_weight, res_ready, mac_intr, mac_fpr,
        input  in_ready, mac_mode, mac_value, mac_weight, mac_ints, mac_fps,
        input  res_valid, res_int, res_fp, busy
    );

    modport slave (
        input  start, mode_cfg, len_cfg, bias_int, bias_fp, abort,
        input  in_valid, in_value, in_weight, res_ready, mac_intr, mac_fpr,
        output in_ready, mac_mode, mac_value, mac_weight, mac_ints, mac_fps,
        output res_valid, res_int, res_fp, busy
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer driving an external combinational MAC datapath.
// Optional macro MAC_SEQ_BIAS_EN: seed the accumulators from bias_int/bias_fp at start.
module mac_seq_ctrl #(
    parameter int LEN_W = 6
) (
    input logic           clk,
    input logic           rst,
    mac_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [3:0]       mode_q, mode_d;
    logic [23:0]      acc_int_q, acc_int_d;
    logic [17:0]      acc_fp_q, acc_fp_d;

    logic [LEN_W:0]   cnt_inc;
    logic [LEN_W:0]   eff_len;
    logic             accept;

    // A programmed length of zero stands for the full 2^LEN_W elements.
    assign eff_len = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
    assign cnt_inc = cnt_q + 1'b1;
    assign accept  = (state_q == RUN) && !bus.abort && bus.in_valid;

`ifndef MAC_SEQ_BIAS_EN
    logic unused_bias;
    assign unused_bias = ^{bus.bias_int, bus.bias_fp};
`endif

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        mode_d    = mode_q;
        acc_int_d = acc_int_q;
        acc_fp_d  = acc_fp_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mode_d  = bus.mode_cfg;
                    len_d   = bus.len_cfg;
                    cnt_d   = '0;
`ifdef MAC_SEQ_BIAS_EN
                    acc_int_d = bus.bias_int;
                    acc_fp_d  = bus.bias_fp;
`else
                    acc_int_d = '0;
                    acc_fp_d  = '0;
`endif
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    acc_int_d = bus.mac_intr;
                    acc_fp_d  = bus.mac_fpr;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == eff_len) state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            mode_q    <= '0;
            acc_int_q <= '0;
            acc_fp_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            acc_int_q <= acc_int_d;
            acc_fp_q  <= acc_fp_d;
        end
    end

    assign bus.in_ready   = accept || ((state_q == RUN) && !bus.abort);
    assign bus.mac_mode   = mode_q;
    assign bus.mac_value  = bus.in_value;
    assign bus.mac_weight = bus.in_weight;
    assign bus.mac_ints   = acc_int_q;
    assign bus.mac_fps    = acc_fp_q;
    assign bus.res_valid  = (state_q == DONE);
    assign bus.res_int    = acc_int_q;
    assign bus.res_fp     = acc_fp_q;
    assign bus.busy       = (state_q == RUN) || (state_q == DONE);
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a small int_s MAC datapath model attached.
// Honours MAC_SEQ_BIAS_EN when computing expected results.
module tb_mac_seq_ctrl;
    localparam int LEN_W = 6;

`ifdef MAC_SEQ_BIAS_EN
    localparam logic [23:0] BIAS_I = 24'd1000;
    localparam logic [17:0] BIAS_F = 18'h00100;
`else
    localparam logic [23:0] BIAS_I = 24'd0;
    localparam logic [17:0] BIAS_F = 18'h00000;
`endif

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    mac_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();

    mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // int_s datapath: signed 8x8 product of the low bytes added to the 24-bit accumulator.
    // The fp lane is modelled as a plain add of the value so its path is observable.
    logic signed [15:0] prod;
    assign prod         = $signed(bus.mac_value[7:0]) * $signed(bus.mac_weight[7:0]);
    assign bus.mac_intr = bus.mac_ints + {{8{prod[15]}}, prod};
    assign bus.mac_fpr  = bus.mac_fps + {2'b00, bus.mac_value};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [LEN_W-1:0] len);
        bus.start    = 1'b1;
        bus.mode_cfg = 4'b0010;
        bus.len_cfg  = len;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [15:0] v, input logic [15:0] w);
        int n = 0;
        bus.in_valid  = 1'b1;
        bus.in_value  = v;
        bus.in_weight = w;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Four-element int_s job: 15 - 14 + 100 + 1 = 102; fp lane sums values 3+7+10+1 = 21.
    task automatic std_job(input string tag, input bit gap);
        start_job(6'd4);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_mode"}, 32'(bus.mac_mode), 32'h2);
        if (gap) bus.start = 1'b1;
        send(16'd3, 16'd5);
        if (gap) @(negedge clk);
        send(16'd7, 16'h00FE);
        if (gap) @(negedge clk);
        send(16'd10, 16'd10);
        bus.start = 1'b0;
        check({tag, "_early_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_acc3"}, 32'(bus.mac_ints), 32'(BIAS_I + 24'd101));
        if (gap) @(negedge clk);
        send(16'd1, 16'd1);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, "_res_int"}, 32'(bus.res_int), 32'(BIAS_I + 24'd102));
        check({tag, "_res_fp"}, 32'(bus.res_fp), 32'(BIAS_F + 18'd21));
    endtask

    task automatic finish_job(input string tag);
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        check({tag, "_valid_clr"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.mode_cfg  = 4'b0000;
        bus.len_cfg   = '0;
        bus.bias_int  = 24'd1000;
        bus.bias_fp   = 18'h00100;
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_value  = '0;
        bus.in_weight = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_res_int", 32'(bus.res_int), 32'd0);
        rst = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("idle_abort_ignored", 32'(bus.busy), 32'd0);

        // Basic job, then result held for 5 cycles with res_ready low.
        std_job("s1", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_res_int", 32'(bus.res_int), 32'(BIAS_I + 24'd102));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_res_valid", 32'(bus.res_valid), 32'd1);
        end
        finish_job("s1");
        @(negedge clk);
        check("start_in_handshake_ignored", 32'(bus.busy), 32'd0);

        // Same job with idle gaps and a stray start held mid-run.
        std_job("s2", 1'b1);
        finish_job("s2");

        // Abort after the second accept, with in_valid asserted alongside.
        start_job(6'd4);
        send(16'd3, 16'd5);
        send(16'd7, 16'h00FE);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_value = 16'd10;
        bus.in_weight = 16'd10;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        check("abort_idle", 32'(bus.busy), 32'd0);
        check("abort_no_result", 32'(bus.res_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_still_no_result", 32'(bus.res_valid), 32'd0);
        std_job("s3", 1'b0);
        finish_job("s3");

        // len_cfg = 0 runs 2^LEN_W = 64 elements.
        start_job('0);
        for (int i = 0; i < 63; i++) send(16'd1, 16'd1);
        check("len0_not_done_63", 32'(bus.res_valid), 32'd0);
        send(16'd1, 16'd1);
        check("len0_done_64", 32'(bus.res_valid), 32'd1);
        check("len0_res_int", 32'(bus.res_int), 32'(BIAS_I + 24'd64));
        check("len0_res_fp", 32'(bus.res_fp), 32'(BIAS_F + 18'd64));
        finish_job("s4");

        // Reset pulsed while a result is waiting in DONE.
        start_job(6'd1);
        send(16'd3, 16'd5);
        check("s5_res_int", 32'(bus.res_int), 32'(BIAS_I + 24'd15));
        rst = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.res_ready = 1'b0;
        check("rst_done_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_done_busy", 32'(bus.busy), 32'd0);
        check("rst_done_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_done_res_int", 32'(bus.res_int), 32'd0);
        check("rst_done_res_fp", 32'(bus.res_fp), 32'd0);
        check("rst_done_mode", 32'(bus.mac_mode), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
